// File: rtl/pwm_multichannel_pkg.sv
// pwm_multichannel_pkg: shared mode enum and default sizing for the PWM block
package pwm_multichannel_pkg;
  typedef enum logic {MODE_EDGE, MODE_CENTER} mode_e;
  localparam int NCH_DEF = 4;
  localparam int CW_DEF = 8;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one channel's active duty, comparator and registered/delayed output
module pwm_channel #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          apply,
  input  logic [CW-1:0] duty_s,
  input  logic [CW-1:0] cnt,
  output logic          pwm_out,
  output logic          pwm_out_d
);
  logic [CW-1:0] duty_a;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      duty_a    <= '0;
      pwm_out   <= 1'b0;
      pwm_out_d <= 1'b0;
    end else begin
      if (apply) duty_a <= duty_s;
      pwm_out   <= en && (cnt < duty_a);
      pwm_out_d <= pwm_out;
    end
endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: shared edge/center-aligned counter with double-buffered period/duty
module pwm_multichannel
  import pwm_multichannel_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [CW-1:0]     period,
  input  logic [NCH*CW-1:0] duty,
  input  logic              load,
  output logic              pending,
  output logic              sync,
  output logic [NCH-1:0]    pwm_out,
  output logic [NCH-1:0]    pwm_out_d
);
  mode_e             mode_s, mode_a;
  logic [CW-1:0]     period_s, period_a, cnt, cnt_n;
  logic [NCH*CW-1:0] duty_s;
  logic              up, up_n, load_q, terminal, apply, top;
  always_comb begin
    top      = up && (cnt == period_a);
    terminal = en && ((period_a == '0) ||
               ((mode_a == MODE_EDGE) ? (cnt == period_a)
                                      : ((cnt == CW'(1)) && (!up || (period_a == CW'(1))))));
    apply    = pending && (terminal || (!en && load_q));
    cnt_n    = (!en || terminal) ? '0
             : ((mode_a == MODE_EDGE) || (up && !top)) ? cnt + CW'(1) : cnt - CW'(1);
    up_n     = (!en || terminal) ? 1'b1 : ((mode_a == MODE_CENTER) && top) ? 1'b0 : up;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mode_s   <= MODE_EDGE;
      mode_a   <= MODE_EDGE;
      period_s <= '0;
      period_a <= '0;
      duty_s   <= '0;
      pending  <= 1'b0;
      load_q   <= 1'b0;
      cnt      <= '0;
      up       <= 1'b1;
      sync     <= 1'b0;
    end else begin
      if (load) begin
        mode_s   <= mode_e'(mode);
        period_s <= period;
        duty_s   <= duty;
      end
      if (apply) begin
        mode_a   <= mode_s;
        period_a <= period_s;
      end
      pending <= load || (pending && !apply);
      load_q  <= load;
      cnt     <= cnt_n;
      up      <= up_n;
      sync    <= en && (cnt == '0) && up;
    end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_channel #(.CW(CW)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .apply    (apply),
      .duty_s   (duty_s[i*CW +: CW]),
      .cnt      (cnt),
      .pwm_out  (pwm_out[i]),
      .pwm_out_d(pwm_out_d[i])
    );
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed checks of load staging, edge/center periods, enable and reset
module tb_pwm_multichannel;
  logic        clk = 1'b0;
  logic        reset, en, mode, load;
  logic [7:0]  period;
  logic [31:0] duty;
  logic        pending, sync;
  logic [3:0]  pwm_out, pwm_out_d;
  int checks = 0;
  int errors = 0;
  int hi[4], hd[4], sp[4];
  int ns;
  localparam logic [31:0] D_EDGE = {8'd5, 8'd10, 8'd3, 8'd0};
  always #5 clk = ~clk;
  pwm_multichannel #(.NCH(4), .CW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .period   (period),
    .duty     (duty),
    .load     (load),
    .pending  (pending),
    .sync     (sync),
    .pwm_out  (pwm_out),
    .pwm_out_d(pwm_out_d)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic observe(input int n);
    for (int i = 0; i < 4; i++) begin
      hi[i] = 0;
      hd[i] = 0;
      sp[i] = -1;
    end
    ns = 0;
    for (int k = 0; k < n; k++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        hi[i] += int'(pwm_out[i]);
        hd[i] += int'(pwm_out_d[i]);
      end
      if (sync) begin
        if (ns < 4) sp[ns] = k;
        ns++;
      end
    end
  endtask
  task automatic prog(input logic m, input logic [7:0] p, input logic [31:0] d);
    mode   = m;
    period = p;
    duty   = d;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask
  initial begin
    reset = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; period = '0; duty = '0;
    repeat (2) step();
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_pwm_d", int'(pwm_out_d), 0);
    chk("rst_sync", int'(sync), 0);
    chk("rst_pending", int'(pending), 0);
    reset = 1'b1;
    step();
    en = 1'b1;
    observe(4);
    chk("noload_hi1", hi[1], 0);
    chk("noload_hi2", hi[2], 0);
    chk("noload_sync", ns, 4);
    en = 1'b0;
    step();
    prog(1'b0, 8'd9, D_EDGE);
    chk("edge_load_pending", int'(pending), 1);
    step();
    chk("edge_idle_apply", int'(pending), 0);
    chk("edge_idle_pwm", int'(pwm_out), 0);
    en = 1'b1;
    observe(20);
    chk("edge_hi0", hi[0], 0);
    chk("edge_hi1", hi[1], 6);
    chk("edge_hi2", hi[2], 20);
    chk("edge_hi3", hi[3], 10);
    chk("edge_hd2", hd[2], 19);
    chk("edge_hd1", hd[1], 6);
    chk("edge_nsync", ns, 2);
    chk("edge_sync0", sp[0], 0);
    chk("edge_sync1", sp[1], 10);
    observe(3);
    prog(1'b0, 8'd4, D_EDGE);
    chk("mid_pending", int'(pending), 1);
    observe(5);
    chk("mid_pending_hold", int'(pending), 1);
    chk("mid_no_sync", ns, 0);
    step();
    chk("mid_pending_clr", int'(pending), 0);
    chk("mid_term_sync", int'(sync), 0);
    observe(10);
    chk("p4_nsync", ns, 2);
    chk("p4_sync0", sp[0], 0);
    chk("p4_sync1", sp[1], 5);
    chk("p4_hi1", hi[1], 6);
    chk("p4_hi3", hi[3], 10);
    prog(1'b0, 8'd6, D_EDGE);
    repeat (3) step();
    prog(1'b0, 8'd2, D_EDGE);
    chk("term_load_pending", int'(pending), 1);
    observe(6);
    chk("p6_pending", int'(pending), 1);
    chk("p6_nsync", ns, 1);
    chk("p6_sync0", sp[0], 0);
    chk("p6_hi1", hi[1], 3);
    step();
    chk("p6_pending_clr", int'(pending), 0);
    observe(6);
    chk("p2_nsync", ns, 2);
    chk("p2_sync1", sp[1], 3);
    chk("p2_hi1", hi[1], 6);
    chk("p2_hi0", hi[0], 0);
    observe(2);
    en = 1'b0;
    step();
    chk("drop_pwm", int'(pwm_out), 0);
    chk("drop_sync", int'(sync), 0);
    step();
    chk("drop_pwm_d", int'(pwm_out_d), 0);
    step();
    en = 1'b1;
    step();
    chk("restart_sync", int'(sync), 1);
    chk("restart_pwm", int'(pwm_out), 4'b1110);
    step();
    chk("restart_sync_off", int'(sync), 0);
    en = 1'b0;
    step();
    prog(1'b1, 8'd8, {8'd8, 8'd9, 8'd0, 8'd4});
    step();
    chk("ctr_apply", int'(pending), 0);
    en = 1'b1;
    observe(32);
    chk("ctr_hi0", hi[0], 14);
    chk("ctr_hi1", hi[1], 0);
    chk("ctr_hi2", hi[2], 32);
    chk("ctr_hi3", hi[3], 30);
    chk("ctr_hd0", hd[0], 13);
    chk("ctr_nsync", ns, 2);
    chk("ctr_sync0", sp[0], 0);
    chk("ctr_sync1", sp[1], 16);
    repeat (3) step();
    prog(1'b0, 8'd3, 32'h01010101);
    chk("rstmid_pending", int'(pending), 1);
    repeat (2) step();
    reset = 1'b0;
    #2;
    chk("async_pwm", int'(pwm_out), 0);
    chk("async_pwm_d", int'(pwm_out_d), 0);
    chk("async_sync", int'(sync), 0);
    chk("async_pending", int'(pending), 0);
    repeat (2) step();
    reset = 1'b1;
    observe(5);
    chk("post_rst_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    chk("post_rst_pending", int'(pending), 0);
    chk("post_rst_sync", ns, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
